rsa_exp_ctrl: RTL and testbench

Modular-exponentiation controller for the lab2 RSA datapath: computes y^d mod n by square-and-multiply, LSB-first. It is the initiator side of the Montgomery start/finish handshake: it issues every multiply to one shared Montgomery responder, holds operands, and consumes each result. The RSA top level wires it beside a single Montgomery instance. The top level also supplies the Montgomery-domain base t = y·2^256 mod n.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_exp_ctrl.sv | 134 +++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the lab2 RSA datapath.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_WAIT
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_SQR
    } op_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// LSB-first square-and-multiply controller driving one shared Montgomery multiplier
// through its start/finish handshake.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH    = RSA_WIDTH,
    parameter int EXP_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_n,
    input  logic [EXP_BITS-1:0] i_d,
    input  logic [WIDTH-1:0]    i_t,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_finish,
    output logic                o_mont_start,
    output logic [WIDTH-1:0]    o_mont_n,
    output logic [WIDTH-1:0]    o_mont_a,
    output logic [WIDTH-1:0]    o_mont_b,
    input  logic [WIDTH-1:0]    i_mont_result,
    input  logic                i_mont_finish
);

    localparam int               IDX_W    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_BITS - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t              state_r;
    op_t                 op_r;
    logic [WIDTH-1:0]    n_r;
    logic [WIDTH-1:0]    t_r;
    logic [WIDTH-1:0]    m_r;
    logic [EXP_BITS-1:0] d_r;
    logic [IDX_W-1:0]    index_r;
    logic [IDX_W-1:0]    index_nxt;

    assign index_nxt = index_r + IDX_W'(1);

    // Operands come straight from registers that only change on capture, so they
    // stay stable for the whole multiply.
    assign o_mont_n = n_r;
    assign o_mont_a = (op_r == OP_MUL) ? m_r : t_r;
    assign o_mont_b = t_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= S_IDLE;
            op_r         <= OP_MUL;
            n_r          <= '0;
            t_r          <= '0;
            m_r          <= '0;
            d_r          <= '0;
            index_r      <= '0;
            o_result     <= '0;
            o_finish     <= 1'b1;
            o_mont_start <= 1'b0;
        end else begin
            o_mont_start <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (!o_finish) begin
                        o_finish <= 1'b1;
                        o_result <= m_r;
                    end else if (i_start) begin
                        n_r      <= i_n;
                        d_r      <= i_d;
                        t_r      <= i_t;
                        m_r      <= ONE;
                        index_r  <= '0;
                        o_finish <= 1'b0;
                        if (i_d[0]) begin
                            op_r         <= OP_MUL;
                            state_r      <= S_REQ;
                            o_mont_start <= 1'b1;
                        end else if (LAST_IDX == '0) begin
                            // Single zero bit: nothing to compute, finish next cycle with 1.
                            op_r <= OP_SQR;
                        end else begin
                            op_r         <= OP_SQR;
                            state_r      <= S_REQ;
                            o_mont_start <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    state_r <= S_ACK;
                end
                S_ACK: begin
                    if (!i_mont_finish) begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mont_finish) begin
                        if (op_r == OP_MUL) begin
                            m_r <= i_mont_result;
                            if (index_r == LAST_IDX) begin
                                state_r  <= S_IDLE;
                                o_finish <= 1'b1;
                                o_result <= i_mont_result;
                            end else begin
                                op_r         <= OP_SQR;
                                state_r      <= S_REQ;
                                o_mont_start <= 1'b1;
                            end
                        end else begin
                            t_r     <= i_mont_result;
                            index_r <= index_nxt;
                            if (d_r[index_nxt]) begin
                                op_r         <= OP_MUL;
                                state_r      <= S_REQ;
                                o_mont_start <= 1'b1;
                            end else if (index_nxt == LAST_IDX) begin
                                // The last square is never issued, so a clear top bit ends here.
                                state_r  <= S_IDLE;
                                o_finish <= 1'b1;
                                o_result <= m_r;
                            end else begin
                                op_r         <= OP_SQR;
                                state_r      <= S_REQ;
                                o_mont_start <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Directed and random checks of rsa_exp_ctrl against behavioural Montgomery responders
// and a plain-arithmetic modular exponentiation model.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    localparam int W = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Full-size DUT
    logic         start = 1'b0;
    logic [W-1:0] n_in = '0, d_in = '0, t_in = '0;
    logic [W-1:0] result, mont_n, mont_a, mont_b, mont_result;
    logic         finish, mont_start, mont_finish;

    rsa_exp_ctrl #(.WIDTH(W), .EXP_BITS(256)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_n(n_in), .i_d(d_in), .i_t(t_in),
        .o_result(result), .o_finish(finish),
        .o_mont_start(mont_start), .o_mont_n(mont_n), .o_mont_a(mont_a), .o_mont_b(mont_b),
        .i_mont_result(mont_result), .i_mont_finish(mont_finish)
    );

    // Four-bit exponent DUT for exact op-sequence and latency checks
    logic         s_start = 1'b0;
    logic [W-1:0] s_n_in = '0, s_t_in = '0;
    logic [3:0]   s_d_in = '0;
    logic [W-1:0] s_result, s_mont_n, s_mont_a, s_mont_b, s_mont_result;
    logic         s_finish, s_mont_start, s_mont_finish;

    rsa_exp_ctrl #(.WIDTH(W), .EXP_BITS(4)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(s_start),
        .i_n(s_n_in), .i_d(s_d_in), .i_t(s_t_in),
        .o_result(s_result), .o_finish(s_finish),
        .o_mont_start(s_mont_start), .o_mont_n(s_mont_n), .o_mont_a(s_mont_a), .o_mont_b(s_mont_b),
        .i_mont_result(s_mont_result), .i_mont_finish(s_mont_finish)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Bit-serial Montgomery product a*b*2^-256 mod n
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
        logic [W+1:0] u;
        u = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) u = u + {2'b00, b};
            if (u[0]) u = u + {2'b00, n};
            u = u >> 1;
        end
        if (u >= {2'b00, n}) u = u - {2'b00, n};
        return u[W-1:0];
    endfunction

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] y, input logic [W-1:0] n);
        logic [2*W-1:0] v;
        v = {y, {W{1'b0}}} % {{W{1'b0}}, n};
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexp(input logic [W-1:0] y, input logic [W-1:0] d, input logic [W-1:0] n);
        logic [2*W-1:0] r, yy, nn;
        r  = 1;
        yy = {{W{1'b0}}, y};
        nn = {{W{1'b0}}, n};
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (d[i]) r = (r * yy) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural responder for the full-size DUT, latency programmable
    int lat = 1;
    int cnt = 0;
    int req_count = 0;
    always @(posedge clk) begin
        if (rst) begin
            mont_finish <= 1'b1;
            mont_result <= '0;
            cnt         <= 0;
        end else if (mont_finish && mont_start) begin
            mont_finish <= 1'b0;
            cnt         <= lat - 1;
            req_count   = req_count + 1;
        end else if (!mont_finish) begin
            if (cnt == 0) begin
                mont_finish <= 1'b1;
                mont_result <= mont(mont_a, mont_b, mont_n);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Responder for the small DUT, L=3; logs 1 for a square (a==b), 0 for a multiply
    int         s_cnt = 0;
    int         s_req_count = 0;
    logic [7:0] s_seq = '0;
    always @(posedge clk) begin
        if (rst) begin
            s_mont_finish <= 1'b1;
            s_mont_result <= '0;
            s_cnt         <= 0;
        end else if (s_mont_finish && s_mont_start) begin
            s_mont_finish <= 1'b0;
            s_cnt         <= 2;
            s_req_count   = s_req_count + 1;
            s_seq         = {s_seq[6:0], (s_mont_a == s_mont_b)};
        end else if (!s_mont_finish) begin
            if (s_cnt == 0) begin
                s_mont_finish <= 1'b1;
                s_mont_result <= mont(s_mont_a, s_mont_b, s_mont_n);
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] nv, input logic [W-1:0] dv, input logic [W-1:0] tv);
        @(negedge clk);
        n_in  = nv;
        d_in  = dv;
        t_in  = tv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFinish(input string tag);
        int cycles;
        int budget;
        cycles = 0;
        budget = 600 * (lat + 2) + 20;
        while (!finish && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_done"}, {255'b0, finish}, 1);
    endtask

    initial begin
        logic [W-1:0] rn, ry, rd, rt;
        int           cyc;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_finish", {255'b0, finish}, 1);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_mstart", {255'b0, mont_start}, 0);
        checkOutput("rst_mont_a", mont_a, 0);
        checkOutput("rst_mont_b", mont_b, 0);
        checkOutput("rst_mont_n", mont_n, 0);
        checkOutput("rst_state", 256'(dut.state_r), 256'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // y=5, n=13: t = 5*2^256 mod 13 = 2
        req_count = 0;
        applyStimulus(13, 1, 2);
        waitFinish("d1");
        checkOutput("d1_result", result, 5);
        checkOutput("d1_requests", 256'(req_count), 256);

        req_count = 0;
        applyStimulus(13, 2, 2);
        waitFinish("d2");
        checkOutput("d2_result", result, 12);
        checkOutput("d2_requests", 256'(req_count), 256);

        req_count = 0;
        applyStimulus(13, 0, 2);
        waitFinish("d0");
        checkOutput("d0_result", result, 1);
        checkOutput("d0_requests", 256'(req_count), 255);

        // Start pulse while busy with other operands must be ignored
        req_count = 0;
        applyStimulus(13, 2, 2);
        repeat (10) @(negedge clk);
        n_in  = 11;
        d_in  = 5;
        t_in  = 7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitFinish("busy");
        checkOutput("busy_result", result, 12);
        checkOutput("busy_requests", 256'(req_count), 256);

        // Random vectors back-to-back, restarting in the cycle finish is high
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            rn = rand256() | {1'b1, 255'b0} | 256'd1;
            ry = rand256() % rn;
            rd = rand256();
            rt = to_mont(ry, rn);
            n_in  = rn;
            d_in  = rd;
            t_in  = rt;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput($sformatf("rand%0d_accept", k), {255'b0, finish}, 0);
            waitFinish($sformatf("rand%0d", k));
            checkOutput($sformatf("rand%0d_result", k), result, modexp(ry, rd, rn));
        end

        // Reset while waiting on the responder
        lat = 5;
        applyStimulus(13, 1, 2);
        cyc = 0;
        while (dut.state_r != S_WAIT && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach_wait", 256'(dut.state_r), 256'(S_WAIT));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_finish", {255'b0, finish}, 1);
        checkOutput("midrst_mstart", {255'b0, mont_start}, 0);
        checkOutput("midrst_state", 256'(dut.state_r), 256'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(13, 2, 2);
        waitFinish("after_rst");
        checkOutput("after_rst_result", result, 12);

        // Four-bit exponent, d=3, L=3: MUL,SQR,MUL,SQR,SQR, finish high 26 cycles after start
        s_req_count = 0;
        s_seq       = '0;
        @(negedge clk);
        s_n_in  = 13;
        s_d_in  = 4'h3;
        s_t_in  = 2;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cyc     = 1;
        checkOutput("small_busy", {255'b0, s_finish}, 0);
        while (!s_finish && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("small_latency", 256'(cyc), 26);
        checkOutput("small_result", s_result, 8);
        checkOutput("small_requests", 256'(s_req_count), 5);
        checkOutput("small_ops", {251'b0, s_seq[4:0]}, 256'b01011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
